// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned DEPTH_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT    = $clog2(DEPTH_DEFAULT);
    localparam int unsigned NUM_LANES     = 2;
    localparam int unsigned ZERO_ADDR     = 0;

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

    // Write-back lanes; a higher lane index has priority on address collisions.
    typedef enum logic {
        LANE_ALU = 1'b0,
        LANE_LSU = 1'b1
    } lane_e;

endpackage

// File: rtl/regfile_sb_bank.sv
// Busy scoreboard: one busy bit per register plus an incrementally maintained busy count.
module regfile_sb_bank
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr0_en,
    input  logic [AW-1:0]    clr0_addr,
    input  logic             clr1_en,
    input  logic [AW-1:0]    clr1_addr,
    output logic [DEPTH-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic             set_eff;
    logic             inc;
    logic             dec0;
    logic             dec1;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    always_comb begin
        set_eff  = set_en && !(ZERO_REG && set_addr == AW'(ZERO_ADDR));
        busy_nxt = busy;
        if (clr0_en) busy_nxt[clr0_addr] = 1'b0;
        if (clr1_en) busy_nxt[clr1_addr] = 1'b0;
        if (set_eff) busy_nxt[set_addr] = 1'b1;

        // Count only real transitions: a clear that coincides with a set, a repeated
        // clear address, or a clear of an idle register leaves the popcount unchanged.
        inc  = set_eff && !busy[set_addr];
        dec0 = clr0_en && busy[clr0_addr] && !(set_eff && set_addr == clr0_addr);
        dec1 = clr1_en && busy[clr1_addr]
               && !(clr0_en && clr0_addr == clr1_addr)
               && !(set_eff && set_addr == clr1_addr);

        cnt_nxt = busy_cnt + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec0} - {{AW{1'b0}}, dec1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two write-back lanes, optional bypass and
// a busy scoreboard for WAW/RAW hazard detection.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD*AW-1:0]    raddr,
    output logic [NUM_RD*WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]       rbusy,
    input  logic                    wen0,
    input  logic [AW-1:0]           waddr0,
    input  logic [WIDTH-1:0]        wdata0,
    input  logic                    wen1,
    input  logic [AW-1:0]           waddr1,
    input  logic [WIDTH-1:0]        wdata1,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_addr,
    output logic                    iss_stall,
    output logic [AW:0]             busy_cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wen   [NUM_LANES];
    logic [AW-1:0]    waddr [NUM_LANES];
    logic [WIDTH-1:0] wdata [NUM_LANES];
    logic             wr_ok [NUM_LANES];
    logic [DEPTH-1:0] busy_vec;
    logic             iss_wr_hit;

    always_comb begin
        wen[LANE_ALU]   = wen0;
        waddr[LANE_ALU] = waddr0;
        wdata[LANE_ALU] = wdata0;
        wen[LANE_LSU]   = wen1;
        waddr[LANE_LSU] = waddr1;
        wdata[LANE_LSU] = wdata1;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            wr_ok[l] = wen[l] && !(ZERO_REG && waddr[l] == AW'(ZERO_ADDR));
        end
    end

    // Lanes are applied in index order so the LSU lane wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                if (wr_ok[l]) mem[waddr[l]] <= wdata[l];
            end
        end
    end

    always_comb begin
        iss_wr_hit = (wen0 && waddr0 == iss_addr) || (wen1 && waddr1 == iss_addr);
        iss_stall  = iss_valid && busy_vec[iss_addr] && !iss_wr_hit;
    end

    regfile_sb_bank #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (iss_valid && !iss_stall),
        .set_addr  (iss_addr),
        .clr0_en   (wen0),
        .clr0_addr (waddr0),
        .clr1_en   (wen1),
        .clr1_addr (waddr1),
        .busy      (busy_vec),
        .busy_cnt  (busy_cnt)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] val;
        logic             bsy;

        assign ra = raddr[k*AW +: AW];

        always_comb begin
            val = mem[ra];
            bsy = busy_vec[ra];
            if (BYPASS) begin
                for (int unsigned l = 0; l < NUM_LANES; l++) begin
                    if (wen[l] && waddr[l] == ra) begin
                        val = wdata[l];
                        bsy = 1'b0;
                    end
                end
            end
            if (ZERO_REG && ra == AW'(ZERO_ADDR)) val = '0;
        end

        assign rdata[k*WIDTH +: WIDTH] = val;
        assign rbusy[k]                = bsy;
    end

endmodule
